// File: rtl/btb_ctrl.sv
// Fully associative branch target buffer controller: 8 tag/target lines,
// single-ported lookup/update arbitration, victim choice and LRU-block steering.
module btb_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_NUM   = 8,
  parameter int LINE_SIZE  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lookup_valid,
  output logic                  lookup_ready,
  input  logic [ADDR_WIDTH-1:0] lookup_pc,
  output logic                  resp_valid,
  output logic                  resp_hit,
  output logic [ADDR_WIDTH-1:0] resp_target,
  input  logic                  upd_valid,
  output logic                  upd_ready,
  input  logic [ADDR_WIDTH-1:0] upd_pc,
  input  logic [ADDR_WIDTH-1:0] upd_target,
  input  logic                  upd_taken,
  input  logic                  flush,
  output logic                  busy,
  output logic                  lru_en,
  output logic                  lru_hit,
  output logic [LINE_SIZE-1:0]  lru_hit_line,
  input  logic [LINE_SIZE-1:0]  lru_line
);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t                state_q, state_d;
  logic [LINE_SIZE-1:0]  flush_idx_q, flush_idx_d;
  logic [LINE_NUM-1:0]   valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] tag_q [LINE_NUM];
  logic [ADDR_WIDTH-1:0] tag_d [LINE_NUM];
  logic [ADDR_WIDTH-1:0] tgt_q [LINE_NUM];
  logic [ADDR_WIDTH-1:0] tgt_d [LINE_NUM];
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_hit_q, resp_hit_d;
  logic [ADDR_WIDTH-1:0] resp_target_q, resp_target_d;

  logic                  upd_fire, lkp_fire;
  logic [ADDR_WIDTH-1:0] cmp_pc;
  logic                  hit_any, free_any;
  logic [LINE_SIZE-1:0]  hit_idx, free_idx, victim;
  logic [ADDR_WIDTH-1:0] hit_tgt;

  assign upd_ready    = (state_q == IDLE) && !flush;
  assign lookup_ready = (state_q == IDLE) && !flush && !upd_valid;
  assign upd_fire     = upd_valid && upd_ready;
  assign lkp_fire     = lookup_valid && lookup_ready;

  assign busy        = (state_q == FLUSH);
  assign resp_valid  = resp_valid_q;
  assign resp_hit    = resp_hit_q;
  assign resp_target = resp_target_q;

  // One shared comparator bank: an update always takes priority over a lookup.
  always_comb begin
    cmp_pc   = upd_valid ? upd_pc : lookup_pc;
    hit_any  = 1'b0;
    hit_idx  = '0;
    hit_tgt  = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int unsigned i = 0; i < LINE_NUM; i++) begin
      if (valid_q[i] && (tag_q[i] == cmp_pc)) begin
        hit_any = 1'b1;
        hit_idx = LINE_SIZE'(i);
        hit_tgt = tgt_q[i];
      end
      if (!valid_q[i] && !free_any) begin
        free_any = 1'b1;
        free_idx = LINE_SIZE'(i);
      end
    end
    victim = free_any ? free_idx : lru_line;
  end

  always_comb begin
    state_d       = state_q;
    flush_idx_d   = flush_idx_q;
    valid_d       = valid_q;
    tag_d         = tag_q;
    tgt_d         = tgt_q;
    resp_valid_d  = 1'b0;
    resp_hit_d    = 1'b0;
    resp_target_d = '0;
    lru_en        = 1'b0;
    lru_hit       = 1'b0;
    lru_hit_line  = '0;
    case (state_q)
      IDLE: begin
        if (flush) begin
          state_d     = FLUSH;
          flush_idx_d = '0;
        end else if (upd_fire) begin
          if (hit_any) begin
            if (upd_taken) begin
              tgt_d[hit_idx] = upd_target;
              lru_en         = 1'b1;
              lru_hit        = 1'b1;
              lru_hit_line   = hit_idx;
            end else begin
              valid_d[hit_idx] = 1'b0;
            end
          end else if (upd_taken) begin
            tag_d[victim]   = upd_pc;
            tgt_d[victim]   = upd_target;
            valid_d[victim] = 1'b1;
            lru_en          = 1'b1;
            lru_hit         = 1'b1;
            lru_hit_line    = victim;
          end
        end else if (lkp_fire) begin
          resp_valid_d  = 1'b1;
          resp_hit_d    = hit_any;
          resp_target_d = hit_any ? hit_tgt : '0;
          if (hit_any) begin
            lru_en       = 1'b1;
            lru_hit      = 1'b1;
            lru_hit_line = hit_idx;
          end
        end
      end
      FLUSH: begin
        // Touching lines 0..7 in order leaves line 0 as least recently used.
        valid_d[flush_idx_q] = 1'b0;
        lru_en               = 1'b1;
        lru_hit              = 1'b1;
        lru_hit_line         = flush_idx_q;
        if (flush) begin
          flush_idx_d = '0;
        end else if (flush_idx_q == LINE_SIZE'(LINE_NUM - 1)) begin
          state_d     = IDLE;
          flush_idx_d = '0;
        end else begin
          flush_idx_d = flush_idx_q + LINE_SIZE'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      flush_idx_q   <= '0;
      valid_q       <= '0;
      tag_q         <= '{default: '0};
      tgt_q         <= '{default: '0};
      resp_valid_q  <= 1'b0;
      resp_hit_q    <= 1'b0;
      resp_target_q <= '0;
    end else begin
      state_q       <= state_d;
      flush_idx_q   <= flush_idx_d;
      valid_q       <= valid_d;
      tag_q         <= tag_d;
      tgt_q         <= tgt_d;
      resp_valid_q  <= resp_valid_d;
      resp_hit_q    <= resp_hit_d;
      resp_target_q <= resp_target_d;
    end
  end

endmodule

// File: doc/btb_ctrl.md
# btb_ctrl

Fully associative branch target buffer controller, sitting between fetch (lookup), execute (update) and the per-line LRU counter block. Holds 8 tag/target/valid lines, arbitrates one lookup or one update per cycle, chooses the allocation victim, and drives the LRU block's `en`/`hit`/`hit_line` inputs from its `lru_line` output. Also sequences an 8-cycle flush that invalidates every line and leaves the LRU order deterministic.

## Interface

- `ADDR_WIDTH`, 32: PC and target width; the tag is the full PC.
- `LINE_NUM`, 8: number of BTB lines.
- `LINE_SIZE`, 3: line index width, log2(`LINE_NUM`).

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `lookup_valid`  in  1  fetch lookup request.
- `lookup_ready`  out  1  lookup accepted when `lookup_valid && lookup_ready`.
- `lookup_pc`  in  ADDR_WIDTH  fetch PC.
- `resp_valid`  out  1  one-cycle lookup response strobe.
- `resp_hit`  out  1  lookup PC matched a valid line.
- `resp_target`  out  ADDR_WIDTH  predicted target; 0 on miss.
- `upd_valid`  in  1  execute update request.
- `upd_ready`  out  1  update accepted when `upd_valid && upd_ready`.
- `upd_pc`  in  ADDR_WIDTH  branch PC.
- `upd_target`  in  ADDR_WIDTH  resolved target.
- `upd_taken`  in  1  branch resolved taken.
- `flush`  in  1  invalidate-all request, level-sampled.
- `busy`  out  1  flush in progress.
- `lru_en`  out  1  to LRU `en`.
- `lru_hit`  out  1  to LRU `hit`.
- `lru_hit_line`  out  LINE_SIZE  to LRU `hit_line`.
- `lru_line`  in  LINE_SIZE  from LRU: least recently used line.

## Operation

- States: IDLE, FLUSH. Reset enters IDLE with all valid bits cleared and the flush index at 0.
- IDLE → FLUSH on the edge where `flush` is high. In FLUSH, `flush` high restarts the index at 0. FLUSH → IDLE on the edge after index 7 completes.
- Ready signals, combinational:
  - `upd_ready = (state == IDLE) && !flush`.
  - `lookup_ready = (state == IDLE) && !flush && !upd_valid`.
  - An update therefore always wins over a simultaneous lookup.
- Accepted lookup:
  - `lookup_pc` is compared against all valid tags in the acceptance cycle.
  - On hit at line i: `lru_en=1`, `lru_hit=1`, `lru_hit_line=i` in that cycle.
  - On miss: `lru_en=0`.
  - The response is registered (see Timing).
- Accepted update, with the compare against all valid tags done in the acceptance cycle:
  - Match at i, taken: write `target[i]=upd_target`; drive `lru_en=1`, `lru_hit=1`, `lru_hit_line=i`.
  - Match at i, not taken: clear `valid[i]`; `lru_en=0`.
  - No match, taken: allocate victim v. v is the lowest-index invalid line if any, else `lru_line`. Write tag, target and valid to line v; drive `lru_en=1`, `lru_hit=1`, `lru_hit_line=v`.
  - No match, not taken: no state change; `lru_en=0`.
- Uniqueness: a tag is written only on a miss, so at most one line ever matches. Priority among multiple matches is not required.
- FLUSH cycle with index k:
  - Clear `valid[k]`; drive `lru_en=1`, `lru_hit=1`, `lru_hit_line=k`; increment k.
  - After the flush, line 0 is least recent and `lru_line` reads 0.
- Otherwise `lru_en=0`, `lru_hit=0`, `lru_hit_line=0`.
- `busy = (state == FLUSH)`.

## Timing

- Reset values: `resp_valid=0`, `resp_hit=0`, `resp_target=0`, `busy=0`, `lru_en=0`, `lru_hit=0`, `lru_hit_line=0`.
- Out of reset, `upd_ready=!flush` and `lookup_ready=!flush && !upd_valid`.
- Lookup latency is 1 cycle:
  - `resp_valid/resp_hit/resp_target` are registered and valid on the cycle after acceptance, for exactly one cycle.
  - `resp_valid=0` in cycles with no acceptance; the response has no backpressure.
- Update latency is 1 cycle:
  - A write or invalidate is visible to a lookup accepted on the next cycle.
  - A lookup is never accepted in the same cycle as an update.
- The LRU outputs are combinational in the acceptance or flush cycle, so the LRU counters update on the same edge as the line arrays.
- Flush timing:
  - `flush` asserted in IDLE at edge N: cycles N+1..N+8 are FLUSH with `busy=1`, k = 0..7.
  - IDLE and `ready` return at N+9, if `flush` is low.
  - A lookup response registered at edge N still appears in cycle N+1.
- Reset asserted mid-flush or mid-response: immediate asynchronous return to reset values; a pending response is dropped.

## Test plan

- After reset, lookup 0x1000 → next cycle `resp_valid=1`, `resp_hit=0`, `resp_target=0`, `lru_en` stays 0.
- Update pc=0x1000, target=0x2000, taken, on an empty BTB → allocates line 0 (`lru_hit_line=0`, `lru_en=1`). Lookup 0x1000 next cycle → `resp_hit=1`, `resp_target=0x2000`, `lru_hit_line=0`.
- Fill lines 0..7 with pcs 0x100..0x107, then lookup 0x101 → victim check: taken update for 0x200 with `lru_line` from the model equal to 0 → written to line 0. Lookup 0x100 then misses; 0x200 hits.
- `upd_valid` and `lookup_valid` high in the same cycle → `lookup_ready=0`, the update commits, and the lookup is accepted in the next cycle.
- Not-taken update of resident pc 0x104 → `valid[4]` cleared and `lru_en=0`. The next taken miss allocates line 4 even though `lru_line` is not 4.
- `flush` pulse with 8 valid lines → `busy=1` for 8 cycles with `lru_hit_line` stepping 0..7. All lookups then miss, `lru_line=0`, and `flush` held high with `rst` pulsed low mid-flush returns all outputs to their reset values.
